subpel_sad_accum: RTL and testbench
===================================

// Module: subpel_sad_accum
// PURPOSE
//  Streaming sub-pixel motion-estimation SAD engine; parametrised successor of the per-line
//  fractional abs-diff stage. Per accepted line: interpolates 25 candidates (5 vertical x
//  5 horizontal offsets, half/quarter pel) from three reference lines, abs-diffs vs the
//  original line, accumulates over ROWS lines. Emits 25 block SADs plus best candidate.
//  Sits between reference-window fetch and the motion-vector decision logic.
// PARAMETERS
//  PIX_W  8  pixel bit width
//  NPIX   6  inner pixels per line (reference lines carry NPIX+2 pixels)
//  ROWS   6  lines per block
//  SAD_W  (localparam) PIX_W + $clog2(NPIX*ROWS); 14 at defaults
// PORTS
//  clk          in   1               clock, all regs on posedge
//  rst          in   1               synchronous active-high reset
//  in_valid     in   1               line valid
//  in_ready     out  1               line accepted on in_valid && in_ready
//  in_upper     in   (NPIX+2)*PIX_W  ref line above; pixel p at [p*PIX_W +: PIX_W]
//  in_middle    in   (NPIX+2)*PIX_W  ref line, full-pel row
//  in_lower     in   (NPIX+2)*PIX_W  ref line below
//  in_org       in   NPIX*PIX_W      original pixels, org j aligned to ref pixel j+1
//  out_valid    out  1               block result valid
//  out_ready    in   1               result consumed on out_valid && out_ready
//  out_sad      out  25*SAD_W        SAD of candidate k at [k*SAD_W +: SAD_W]
//  out_best_idx out  5               index of minimum SAD
//  out_best_sad out  SAD_W           minimum SAD
// BEHAVIOUR
//  - Candidate index k = 5*v + hz. v: 0 UH(-1/2), 1 UQ(-1/4), 2 M(0), 3 LQ(+1/4), 4 LH(+1/2).
//    hz: 0 h(-1/2), 1 q(-1/4), 2 f(0), 3 r(+1/4), 4 i(+1/2). Full-pel = 12.
//  - Horizontal, per line X, j=0..NPIX-1, a=X[j], c=X[j+1], b=X[j+2]:
//    h=(a+c+1)>>1, q=(a+3c+2)>>2, f=c, r=(3c+b+2)>>2, i=(c+b+1)>>1.
//  - Vertical on horizontal results U,M,D (same hz, j):
//    UH=(U+M+1)>>1, UQ=(U+3M+2)>>2, M=M, LQ=(3M+D+2)>>2, LH=(M+D+1)>>1.
//  - Intermediates PIX_W+2 bits unsigned; results always fit PIX_W. No saturation needed.
//  - diff = |org_j - cand|, PIX_W bits. Row sum over j; accumulate over rows in SAD_W bits.
//    Max 36*255 = 9180 < 2^14: no overflow by construction.
//  - Pipeline: S0 input regs, S1 25 row-sum regs, S2 accumulators/output regs.
//  - Global enable en = !(out_valid && !out_ready); in_ready = en. When en=0 all stages hold.
//  - row_cnt 0..ROWS-1 increments per accepted line; wraps to 0 after ROWS-1 (last line).
//  - Last line accepted on edge E -> out_valid=1 after edge E+2 (absent stall).
//    out_sad = acc + final row sum. Accumulators clear in the same edge, so the next
//    block's first row starts from 0. Back-to-back blocks are supported at full rate.
//  - Non-last rows: acc <= acc + row sum; no output change.
//  - out_* stable while out_valid && !out_ready. out_valid drops on the handshake edge
//    unless a new result loads in that same edge; then it stays 1 with new data.
//  - best: strict-less comparison scanning k=0..24, so ties give the lowest index.
//    Computed from the final sums and registered with out_sad.
//  - Bubbles (in_valid=0) advance as invalid stage entries and are not accumulated.
//  - Reset, including mid-block: row_cnt=0, accumulators=0, stage valids=0, out_valid=0,
//    out_sad=0, out_best_idx=0, out_best_sad=0, in_ready=1. Partial block discarded.
// TESTING
//  1 All ref/org=100, 6 lines -> all 25 SADs=0, best_idx=0, best_sad=0.
//  2 upper=0, middle=100, lower=200, org=100 -> SAD rows v0..v4 = 1800,900,0,900,1800
//    for every hz; best_idx=10, best_sad=0.
//  3 Ref=255, org=0 -> all SADs=9180 (no wrap); best_idx=0.
//  4 Hold out_ready=0 for 5 cycles after out_valid -> in_ready=0, out_* unchanged,
//    no line lost; release -> next block result correct.
//  5 rst after 3 lines of pattern B, then 6 lines of test-2 data -> test-2 result only;
//    out_valid never asserted for the aborted block.
//  6 12 continuous lines, out_ready=1 -> two results exactly 6 cycles apart, each correct
//    per its own block; second shows no carry-over from the first.

Source files
------------

// File: rtl/subpel_sad_accum.sv
// subpel_sad_accum
// Streaming sub-pixel SAD engine. Each accepted line carries three reference
// lines (upper/middle/lower, NPIX+2 pixels each) and NPIX original pixels.
// 25 candidates (5 vertical x 5 horizontal fractional offsets, index 5*v+hz)
// are interpolated, abs-diffed against the original and summed per line, then
// accumulated over ROWS lines. The block result reports all 25 SADs plus the
// lowest-index minimum.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   line handshake (in_ready is the global pipeline enable)
//   in_upper/middle/lower  reference lines, pixel p at [p*PIX_W +: PIX_W]
//   in_org              original line, org j aligned to reference pixel j+1
//   out_valid/out_ready block result handshake
//   out_sad             25 block SADs, candidate k at [k*SAD_W +: SAD_W]
//   out_best_idx/sad    first minimum over k = 0..24
module subpel_sad_accum #(
   parameter int PIX_W = 8,
   parameter int NPIX  = 6,
   parameter int ROWS  = 6
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [(NPIX+2)*PIX_W-1:0]         in_upper,
   input  logic [(NPIX+2)*PIX_W-1:0]         in_middle,
   input  logic [(NPIX+2)*PIX_W-1:0]         in_lower,
   input  logic [NPIX*PIX_W-1:0]             in_org,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [25*(PIX_W+$clog2(NPIX*ROWS))-1:0] out_sad,
   output logic [4:0]                        out_best_idx,
   output logic [PIX_W+$clog2(NPIX*ROWS)-1:0] out_best_sad
);

   localparam int SAD_W  = PIX_W + $clog2(NPIX*ROWS);
   localparam int EXT_W  = PIX_W + 2;
   localparam int NCAND  = 25;
   localparam int LINE_W = (NPIX+2)*PIX_W;
   localparam int ORG_W  = NPIX*PIX_W;
   localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS-1);

   // One fractional tap on three neighbours a (before), c (centre), b (after).
   // sel 0:-1/2, 1:-1/4, 2:0, 3:+1/4, 4:+1/2. Shared by both directions.
   function automatic logic [PIX_W-1:0] frac_interp(input logic [PIX_W-1:0] a,
                                                    input logic [PIX_W-1:0] c,
                                                    input logic [PIX_W-1:0] b,
                                                    input logic [2:0]       sel);
      logic [EXT_W-1:0] ea, ec, eb, t;
      ea = EXT_W'(a);
      ec = EXT_W'(c);
      eb = EXT_W'(b);
      case (sel)
         3'd0:    t = (ea + ec + EXT_W'(2'd1)) >> 1'd1;
         3'd1:    t = (ea + ec + ec + ec + EXT_W'(2'd2)) >> 2'd2;
         3'd2:    t = ec;
         3'd3:    t = (ec + ec + ec + eb + EXT_W'(2'd2)) >> 2'd2;
         3'd4:    t = (ec + eb + EXT_W'(2'd1)) >> 1'd1;
         default: t = ec;
      endcase
      return PIX_W'(t);
   endfunction

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] x,
                                                 input logic [PIX_W-1:0] y);
      return (x > y) ? (x - y) : (y - x);
   endfunction

   logic                 en_s;
   logic [CNT_W-1:0]     row_cnt_r;
   logic                 s0_valid_r, s0_last_r;
   logic [LINE_W-1:0]    s0_upper_r, s0_middle_r, s0_lower_r;
   logic [ORG_W-1:0]     s0_org_r;
   logic [SAD_W-1:0]     row_sum_s [NCAND];
   logic                 s1_valid_r, s1_last_r;
   logic [SAD_W-1:0]     s1_sum_r  [NCAND];
   logic [SAD_W-1:0]     acc_r     [NCAND];
   logic [SAD_W-1:0]     fin_s     [NCAND];
   logic [4:0]           best_idx_s;
   logic [SAD_W-1:0]     best_sad_s;
   logic                 out_valid_r;
   logic [SAD_W-1:0]     out_sad_r [NCAND];
   logic [4:0]           out_best_idx_r;
   logic [SAD_W-1:0]     out_best_sad_r;

   // A held result that is not being taken freezes the whole pipeline.
   assign en_s     = !(out_valid_r && !out_ready);
   assign in_ready = en_s;

   // Stage 0: capture the line and tag whether it closes the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_r   <= '0;
         s0_valid_r  <= 1'b0;
         s0_last_r   <= 1'b0;
         s0_upper_r  <= '0;
         s0_middle_r <= '0;
         s0_lower_r  <= '0;
         s0_org_r    <= '0;
      end else if (en_s) begin
         s0_valid_r <= in_valid;
         if (in_valid) begin
            s0_upper_r  <= in_upper;
            s0_middle_r <= in_middle;
            s0_lower_r  <= in_lower;
            s0_org_r    <= in_org;
            s0_last_r   <= (row_cnt_r == LAST_ROW);
            row_cnt_r   <= (row_cnt_r == LAST_ROW) ? '0 : row_cnt_r + CNT_W'(1'b1);
         end
      end
   end

   // Per-line candidate sums: horizontal tap on each reference line, then a
   // vertical tap across the three horizontal results.
   always_comb begin
      for (int k = 0; k < NCAND; k++) row_sum_s[k] = '0;
      for (int v = 0; v < 5; v++) begin
         for (int hz = 0; hz < 5; hz++) begin
            for (int j = 0; j < NPIX; j++) begin
               row_sum_s[v*5+hz] = row_sum_s[v*5+hz] + SAD_W'(abs_diff(
                  s0_org_r[j*PIX_W +: PIX_W],
                  frac_interp(
                     frac_interp(s0_upper_r[j*PIX_W +: PIX_W], s0_upper_r[(j+1)*PIX_W +: PIX_W],
                                 s0_upper_r[(j+2)*PIX_W +: PIX_W], 3'(hz)),
                     frac_interp(s0_middle_r[j*PIX_W +: PIX_W], s0_middle_r[(j+1)*PIX_W +: PIX_W],
                                 s0_middle_r[(j+2)*PIX_W +: PIX_W], 3'(hz)),
                     frac_interp(s0_lower_r[j*PIX_W +: PIX_W], s0_lower_r[(j+1)*PIX_W +: PIX_W],
                                 s0_lower_r[(j+2)*PIX_W +: PIX_W], 3'(hz)),
                     3'(v))));
            end
         end
      end
   end

   // Stage 1: register the 25 line sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         for (int k = 0; k < NCAND; k++) s1_sum_r[k] <= '0;
      end else if (en_s) begin
         s1_valid_r <= s0_valid_r;
         s1_last_r  <= s0_last_r;
         for (int k = 0; k < NCAND; k++) s1_sum_r[k] <= row_sum_s[k];
      end
   end

   // Running totals including the line now in stage 1, and their first minimum.
   always_comb begin
      for (int k = 0; k < NCAND; k++) fin_s[k] = acc_r[k] + s1_sum_r[k];
      best_idx_s = 5'd0;
      best_sad_s = fin_s[0];
      for (int k = 1; k < NCAND; k++) begin
         if (fin_s[k] < best_sad_s) begin
            best_idx_s = 5'(k);
            best_sad_s = fin_s[k];
         end else begin
            best_idx_s = best_idx_s;
         end
      end
   end

   // Stage 2: accumulate; on the closing line publish and restart from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r    <= 1'b0;
         out_best_idx_r <= 5'd0;
         out_best_sad_r <= '0;
         for (int k = 0; k < NCAND; k++) begin
            acc_r[k]     <= '0;
            out_sad_r[k] <= '0;
         end
      end else if (en_s) begin
         out_valid_r <= s1_valid_r && s1_last_r;
         if (s1_valid_r && s1_last_r) begin
            out_best_idx_r <= best_idx_s;
            out_best_sad_r <= best_sad_s;
            for (int k = 0; k < NCAND; k++) begin
               acc_r[k]     <= '0;
               out_sad_r[k] <= fin_s[k];
            end
         end else if (s1_valid_r) begin
            for (int k = 0; k < NCAND; k++) acc_r[k] <= fin_s[k];
         end
      end
   end

   genvar gk;
   generate
      for (gk = 0; gk < NCAND; gk++) begin : g_pack
         assign out_sad[gk*SAD_W +: SAD_W] = out_sad_r[gk];
      end
   endgenerate

   assign out_valid    = out_valid_r;
   assign out_best_idx = out_best_idx_r;
   assign out_best_sad = out_best_sad_r;

endmodule

// File: tb/tb_subpel_sad_accum.sv
// Randomised bench for subpel_sad_accum against a weight-table reference model.
module tb_subpel_sad_accum;

   localparam int PIX_W = 8;
   localparam int NPIX  = 6;
   localparam int ROWS  = 6;
   localparam int SAD_W = 14;
   localparam int NC    = 25;

   typedef struct packed {
      logic [NC-1:0][15:0] sad;
      logic [4:0]          bidx;
      logic [15:0]         bsad;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [(NPIX+2)*PIX_W-1:0] in_upper = '0, in_middle = '0, in_lower = '0;
   logic [NPIX*PIX_W-1:0]     in_org = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [NC*SAD_W-1:0] out_sad;
   logic [4:0]          out_best_idx;
   logic [SAD_W-1:0]    out_best_sad;

   subpel_sad_accum #(.PIX_W(PIX_W), .NPIX(NPIX), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_upper(in_upper), .in_middle(in_middle), .in_lower(in_lower), .in_org(in_org),
      .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad),
      .out_best_idx(out_best_idx), .out_best_sad(out_best_sad));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t exp_q[$];
   int   hs_cyc[$];
   exp_t exp_a, mon_e;

   logic [7:0] bu [ROWS][NPIX+2];
   logic [7:0] bm [ROWS][NPIX+2];
   logic [7:0] bl [ROWS][NPIX+2];
   logic [7:0] bo [ROWS][NPIX];

   // Fractional taps as quarter-pel weights on (before, centre, after), rounded.
   int wa[5] = '{2, 1, 0, 0, 0};
   int wc[5] = '{2, 3, 4, 3, 2};
   int wb[5] = '{0, 0, 0, 1, 2};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wavg(input int a, input int c, input int b, input int s);
      return (wa[s]*a + wc[s]*c + wb[s]*b + 2) / 4;
   endfunction

   function automatic exp_t model();
      exp_t e;
      int s, hu, hm, hd, cand, d, bs;
      e = '0;
      for (int k = 0; k < NC; k++) begin
         s = 0;
         for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < NPIX; j++) begin
               hu = wavg(int'(bu[r][j]), int'(bu[r][j+1]), int'(bu[r][j+2]), k % 5);
               hm = wavg(int'(bm[r][j]), int'(bm[r][j+1]), int'(bm[r][j+2]), k % 5);
               hd = wavg(int'(bl[r][j]), int'(bl[r][j+1]), int'(bl[r][j+2]), k % 5);
               cand = wavg(hu, hm, hd, k / 5);
               d = int'(bo[r][j]) - cand;
               s += (d < 0) ? -d : d;
            end
         end
         e.sad[k] = 16'(s);
      end
      bs = int'(e.sad[0]);
      e.bidx = 5'd0;
      for (int k = 1; k < NC; k++) begin
         if (int'(e.sad[k]) < bs) begin
            bs = int'(e.sad[k]);
            e.bidx = 5'(k);
         end
      end
      e.bsad = 16'(bs);
      return e;
   endfunction

   task automatic fill_const(input int u, input int m, input int l, input int o);
      for (int r = 0; r < ROWS; r++) begin
         for (int p = 0; p < NPIX+2; p++) begin
            bu[r][p] = 8'(u); bm[r][p] = 8'(m); bl[r][p] = 8'(l);
         end
         for (int j = 0; j < NPIX; j++) bo[r][j] = 8'(o);
      end
   endtask

   task automatic fill_rand();
      for (int r = 0; r < ROWS; r++) begin
         for (int p = 0; p < NPIX+2; p++) begin
            bu[r][p] = 8'($urandom_range(0, 255));
            bm[r][p] = 8'($urandom_range(0, 255));
            bl[r][p] = 8'($urandom_range(0, 255));
         end
         for (int j = 0; j < NPIX; j++) bo[r][j] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic send_line(input int r);
      int n;
      @(negedge clk);
      for (int p = 0; p < NPIX+2; p++) begin
         in_upper[p*PIX_W +: PIX_W]  = bu[r][p];
         in_middle[p*PIX_W +: PIX_W] = bm[r][p];
         in_lower[p*PIX_W +: PIX_W]  = bl[r][p];
      end
      for (int j = 0; j < NPIX; j++) in_org[j*PIX_W +: PIX_W] = bo[r][j];
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_block(input bit bubbles);
      for (int r = 0; r < ROWS; r++) begin
         send_line(r);
         if (bubbles && $urandom_range(0, 2) == 0) idle();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      #2;
      check("drain", exp_q.size(), 0);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_best_idx"}, out_best_idx, 0);
      check({tag, "_best_sad"}, out_best_sad, 0);
      check({tag, "_out_sad_nonzero"}, (out_sad == '0) ? 0 : 1, 0);
   endtask

   // Result monitor: every handshake must match the oldest outstanding block.
   always begin
      @(negedge clk); #1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            for (int k = 0; k < NC; k++)
               check($sformatf("sad%0d", k), int'(out_sad[k*SAD_W +: SAD_W]), int'(mon_e.sad[k]));
            check("best_idx", out_best_idx, int'(mon_e.bidx));
            check("best_sad", out_best_sad, int'(mon_e.bsad));
            hs_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      int n, n0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      reset_checks("rst");
      @(negedge clk);
      rst = 1'b0;

      // flat, vertical gradient, saturated extremes
      fill_const(100, 100, 100, 100); exp_q.push_back(model()); send_block(1'b0);
      fill_const(0, 100, 200, 100);   exp_q.push_back(model()); send_block(1'b0);
      fill_const(255, 255, 255, 0);   exp_q.push_back(model()); send_block(1'b0);
      idle();
      drain();

      // result held back for five cycles while the next block is presented
      @(negedge clk);
      out_ready = 1'b0;
      fill_rand(); exp_a = model(); exp_q.push_back(exp_a); send_block(1'b0);
      fill_rand(); exp_q.push_back(model());
      fork
         begin
            send_block(1'b0);
            idle();
         end
         begin : stall
            int m;
            m = 0;
            @(negedge clk); #1;
            while (!out_valid && m < 50) begin
               @(negedge clk); #1; m++;
            end
            check("stall_out_valid", out_valid, 1);
            for (int i = 0; i < 5; i++) begin
               check("stall_in_ready", in_ready, 0);
               check("stall_sad0", int'(out_sad[SAD_W-1:0]), int'(exp_a.sad[0]));
               check("stall_sad24", int'(out_sad[24*SAD_W +: SAD_W]), int'(exp_a.sad[24]));
               check("stall_best_sad", out_best_sad, int'(exp_a.bsad));
               @(negedge clk); #1;
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // reset in the middle of a block discards it
      fill_rand();
      for (int r = 0; r < 3; r++) send_line(r);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      reset_checks("midrst");
      @(negedge clk);
      rst = 1'b0;
      fill_const(0, 100, 200, 100); exp_q.push_back(model()); send_block(1'b0);
      idle();
      drain();

      // two blocks back to back at full rate
      n0 = hs_cyc.size();
      fill_rand(); exp_q.push_back(model()); send_block(1'b0);
      fill_rand(); exp_q.push_back(model()); send_block(1'b0);
      idle();
      drain();
      n = hs_cyc.size();
      if (n - n0 == 2) check("b2b_spacing", hs_cyc[n0+1] - hs_cyc[n0], 6);
      else check("b2b_count", n - n0, 2);

      // random blocks with bubbles
      for (int b = 0; b < 3; b++) begin
         fill_rand(); exp_q.push_back(model()); send_block(1'b1);
      end
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
